// File: rtl/onchip_memory_pkg.sv
// Shared types and helpers for the dual-port on-chip RAM.
package onchip_memory_pkg;

  // Read-during-write behaviour across ports: the reader sees the pre-write word.
  typedef enum logic {
    OLD_DATA = 1'b0,
    NEW_DATA = 1'b1
  } rdw_policy_e;

  // Same-address write/write resolution, decided per byte lane.
  typedef enum logic {
    PORT1_WINS = 1'b0,
    PORT2_WINS = 1'b1
  } ww_policy_e;

  // Cycles from read acceptance to readdatavalid, counted in enabled cycles.
  function automatic int read_latency(input int output_reg);
    return (output_reg != 0) ? 2 : 1;
  endfunction

  // One byte-enable bit per 8-bit lane.
  function automatic int be_width(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/onchip_memory_dp_if.sv
// Avalon-MM slave signal bundle for one RAM port.
interface onchip_memory_dp_if #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] address;
  logic                  chipselect;
  logic                  read;
  logic                  write;
  logic [BE_WIDTH-1:0]   byteenable;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    output readdata, readdatavalid
  );
endinterface

// File: rtl/onchip_memory_dp_core.sv
// True dual-port byte-lane RAM array with registered, old-data reads.
module onchip_ram_tdp_core #(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 2048,
  parameter int    ADDR_WIDTH = 11,
  parameter int    BE_WIDTH   = 4,
  parameter string INIT_FILE  = ""
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] a1,
  input  logic                  re1,
  input  logic [BE_WIDTH-1:0]   we1,
  input  logic [DATA_WIDTH-1:0] wd1,
  output logic [DATA_WIDTH-1:0] q1,
  input  logic [ADDR_WIDTH-1:0] a2,
  input  logic                  re2,
  input  logic [BE_WIDTH-1:0]   we2,
  input  logic [DATA_WIDTH-1:0] wd2,
  output logic [DATA_WIDTH-1:0] q2
);

  logic [BE_WIDTH-1:0][7:0] mem [DEPTH];
  logic [BE_WIDTH-1:0][7:0] wd1_l;
  logic [BE_WIDTH-1:0][7:0] wd2_l;

  assign wd1_l = wd1;
  assign wd2_l = wd2;

  // Registered reads and per-lane writes; reads sample the pre-edge word (old data).
  // NOTE: the array and read registers have no reset; RAM contents must survive reset and
  // block RAMs cannot be cleared in one cycle anyway.
  always_ff @(posedge clk) begin
    if (re1) q1 <= mem[a1];
    if (re2) q2 <= mem[a2];
    for (int b = 0; b < BE_WIDTH; b++) begin
      if (we2[b]) mem[a2][b] <= wd2_l[b];
      if (we1[b]) mem[a1][b] <= wd1_l[b];
    end
  end

endmodule

// File: rtl/onchip_memory_dp.sv
// Dual-port on-chip RAM with two Avalon-MM slaves, pipelined reads and collision rules.
module onchip_memory_dp
  import onchip_memory_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 2048,
  parameter int    OUTPUT_REG = 0,
  parameter int    DUAL_PORT  = 1,
  parameter string INIT_FILE  = ""
) (
  input logic               clk,
  input logic               reset,
  input logic               reset_req,
  input logic               clken,
  onchip_memory_dp_if.slave s1,
  onchip_memory_dp_if.slave s2
);

  localparam int         ADDR_WIDTH = $clog2(DEPTH);
  localparam int         BE_WIDTH   = be_width(DATA_WIDTH);
  localparam int         LATENCY    = read_latency(OUTPUT_REG);
  localparam ww_policy_e WW_POLICY  = PORT1_WINS;

  logic                  en;
  logic                  adv;
  logic                  p2_on;
  logic                  wr1, rd1, in1;
  logic                  wr2, rd2, in2;
  logic                  collide;
  logic [BE_WIDTH-1:0]   be2_eff;
  logic [BE_WIDTH-1:0]   we1, we2;
  logic [DATA_WIDTH-1:0] q1, q2;

  // Pipeline stage 1 (RAM read register) qualifiers.
  logic [1:0]                 v1_q, v1_d;
  logic [1:0]                 oor1_q, oor1_d;
  logic [1:0][DATA_WIDTH-1:0] d1;

  // Last pipeline stage as seen by the ports.
  logic [1:0]                 last_v;
  logic [1:0][DATA_WIDTH-1:0] last_data;

  assign en    = clken & ~reset_req;
  assign adv   = en & ~reset;
  assign p2_on = (DUAL_PORT != 0);

  // Accept, range check and write/write collision masking.
  // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    wr1     = adv & s1.chipselect & s1.write;
    rd1     = adv & s1.chipselect & s1.read & ~s1.write;
    in1     = 32'(s1.address) < DEPTH;
    wr2     = p2_on & adv & s2.chipselect & s2.write;
    rd2     = p2_on & adv & s2.chipselect & s2.read & ~s2.write;
    in2     = 32'(s2.address) < DEPTH;
    collide = wr1 & wr2 & in1 & in2 & (s1.address == s2.address);
    be2_eff = s2.byteenable;
    if (collide && WW_POLICY == PORT1_WINS) be2_eff = s2.byteenable & ~s1.byteenable;
    we1 = (wr1 & in1) ? s1.byteenable : '0;
    we2 = (wr2 & in2) ? be2_eff : '0;
  end

  onchip_ram_tdp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BE_WIDTH   (BE_WIDTH),
    .INIT_FILE  (INIT_FILE)
  ) u_core (
    .clk (clk),
    .a1  (s1.address),
    .re1 (rd1 & in1),
    .we1 (we1),
    .wd1 (s1.writedata),
    .q1  (q1),
    .a2  (s2.address),
    .re2 (rd2 & in2),
    .we2 (we2),
    .wd2 (s2.writedata),
    .q2  (q2)
  );

  // Out-of-range reads never touch the array and return zero.
  assign d1[0] = oor1_q[0] ? '0 : q1;
  assign d1[1] = oor1_q[1] ? '0 : q2;

  // Stage-1 valid/range bits advance only in enabled cycles, otherwise hold.
  always_comb begin
    v1_d   = v1_q;
    oor1_d = oor1_q;
    if (adv) begin
      v1_d   = {rd2, rd1};
      oor1_d = {rd2 & ~in2, rd1 & ~in1};
    end
  end

  // Stage-1 qualifier registers; reset drops any in-flight read.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= '0;
      oor1_q <= '0;
    end else begin
      v1_q   <= v1_d;
      oor1_q <= oor1_d;
    end
  end

  if (LATENCY > 1) begin : g_oreg
    logic [1:0]                 v2_q, v2_d;
    logic [1:0][DATA_WIDTH-1:0] dat2_q, dat2_d;

    // Output register stage, advancing together with stage 1.
    always_comb begin
      v2_d   = v2_q;
      dat2_d = dat2_q;
      if (adv) begin
        v2_d   = v1_q;
        dat2_d = d1;
      end
    end

    // Output register flops, cleared by reset.
    always_ff @(posedge clk) begin
      if (reset) begin
        v2_q   <= '0;
        dat2_q <= '0;
      end else begin
        v2_q   <= v2_d;
        dat2_q <= dat2_d;
      end
    end

    assign last_v    = v2_q;
    assign last_data = dat2_q;
  end else begin : g_noreg
    assign last_v    = v1_q;
    assign last_data = d1;
  end

  // A stalled or resetting port shows no valid; readdata reads zero unless a beat is held.
  assign s1.readdatavalid = last_v[0] & adv;
  assign s1.readdata      = (last_v[0] & ~reset) ? last_data[0] : '0;
  assign s2.readdatavalid = last_v[1] & adv;
  assign s2.readdata      = (last_v[1] & ~reset) ? last_data[1] : '0;

endmodule

// File: tb/tb_onchip_memory_dp.sv
// Self-checking bench: three RAM configurations driven with one stimulus stream.
//   dut 0: OUTPUT_REG=0, DEPTH=2048   dut 1: OUTPUT_REG=1, DEPTH=2048   dut 2: OUTPUT_REG=0, DEPTH=1000
module tb_onchip_memory_dp;

  typedef struct {
    logic [31:0] data;
    int          cnt;
  } pend_t;

  localparam int LAT    [3] = '{1, 2, 1};
  localparam int DEPTHS [3] = '{2048, 2048, 1000};

  logic clk;
  logic reset, reset_req, clken;
  logic        cs   [2];
  logic        rd   [2];
  logic        wr   [2];
  logic [10:0] addr [2];
  logic [3:0]  be   [2];
  logic [31:0] wd   [2];

  logic [2:0][1:0]        rval;
  logic [2:0][1:0][31:0]  rdat;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    vcount = 0;
  pend_t pend [6][$];
  logic [31:0] mm [3][2048];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int DP   = (g == 2) ? 1000 : 2048;
    localparam int AW   = $clog2(DP);
    localparam int OREG = (g == 1) ? 1 : 0;

    onchip_memory_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) p1 ();
    onchip_memory_dp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) p2 ();

    assign p1.address    = addr[0][AW-1:0];
    assign p1.chipselect = cs[0];
    assign p1.read       = rd[0];
    assign p1.write      = wr[0];
    assign p1.byteenable = be[0];
    assign p1.writedata  = wd[0];
    assign p2.address    = addr[1][AW-1:0];
    assign p2.chipselect = cs[1];
    assign p2.read       = rd[1];
    assign p2.write      = wr[1];
    assign p2.byteenable = be[1];
    assign p2.writedata  = wd[1];

    onchip_memory_dp #(
      .DATA_WIDTH (32),
      .DEPTH      (DP),
      .OUTPUT_REG (OREG),
      .DUAL_PORT  (1),
      .INIT_FILE  ("")
    ) dut (
      .clk       (clk),
      .reset     (reset),
      .reset_req (reset_req),
      .clken     (clken),
      .s1        (p1),
      .s2        (p2)
    );

    assign rval[g][0] = p1.readdatavalid;
    assign rval[g][1] = p2.readdatavalid;
    assign rdat[g][0] = p1.readdata;
    assign rdat[g][1] = p2.readdata;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: memory image plus per-port queue of pending read beats.
  // Each beat carries the number of further enabled cycles it must wait before showing.
  always @(posedge clk) begin
    logic adv;
    adv = clken & ~reset_req & ~reset;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        for (int p = 0; p < 2; p++) pend[d*2+p].delete();
      end else if (adv) begin
        for (int p = 0; p < 2; p++) begin
          int k;
          k = d*2 + p;
          if (pend[k].size() > 0 && pend[k][0].cnt == 0) void'(pend[k].pop_front());
          foreach (pend[k][i]) pend[k][i].cnt--;
          if (cs[p] && rd[p] && !wr[p])
            pend[k].push_back('{data: (int'(addr[p]) < DEPTHS[d]) ? mm[d][addr[p]] : 32'h0,
                                cnt:  LAT[d] - 1});
        end
        // Port 2 first, then port 1 on top: port 1 owns any lane both wrote.
        for (int p = 1; p >= 0; p--) begin
          if (cs[p] && wr[p] && int'(addr[p]) < DEPTHS[d])
            for (int b = 0; b < 4; b++)
              if (be[p][b]) mm[d][addr[p]][b*8 +: 8] = wd[p][b*8 +: 8];
        end
      end
    end
  end

  // Compare every DUT port against the model on every cycle.
  always @(negedge clk) begin
    logic en, ev;
    en = clken & ~reset_req;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 2; p++) begin
        int k;
        k  = d*2 + p;
        ev = !reset && en && pend[k].size() > 0 && pend[k][0].cnt == 0;
        check($sformatf("valid d%0d s%0d", d, p + 1), 32'(rval[d][p]), 32'(ev));
        if (ev) check($sformatf("data d%0d s%0d", d, p + 1), rdat[d][p], pend[k][0].data);
        if (reset) check($sformatf("rst_data d%0d s%0d", d, p + 1), rdat[d][p], 32'h0);
      end
    end
    if (rval[0][0]) vcount++;
  end

  task automatic idle();
    for (int p = 0; p < 2; p++) begin
      cs[p] = 1'b0; rd[p] = 1'b0; wr[p] = 1'b0;
      addr[p] = '0; be[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic op(input int p, input bit w, input bit r, input int a,
                    input logic [3:0] b, input logic [31:0] d);
    cs[p] = 1'b1; wr[p] = w; rd[p] = r;
    addr[p] = 11'(a); be[p] = b; wd[p] = d;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; reset_req = 1'b0; clken = 1'b1;
    idle();
    #3;
    check("lit reset valid", 32'(rval[0][0]), 32'h0);
    check("lit reset data", rdat[0][0], 32'h0);
    step(); step();
    reset = 1'b0;

    // Prefill words 0..3 from s1 and word 4 from s2.
    for (int i = 0; i < 4; i++) begin
      op(0, 1, 0, i, 4'hF, 32'h1000_0000 + i);
      if (i == 0) op(1, 1, 0, 4, 4'hF, 32'h0404_0404);
      step();
      idle();
    end

    // Full-word write then read: L=1 on dut 0, L=2 on dut 1.
    op(0, 1, 0, 5, 4'hF, 32'hDEAD_BEEF); step();
    op(0, 0, 1, 5, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t1 valid L1", 32'(rval[0][0]), 32'h1);
    check("lit t1 data L1", rdat[0][0], 32'hDEAD_BEEF);
    check("lit t1 early L2", 32'(rval[1][0]), 32'h0);
    step(); #2;
    check("lit t1 valid L2", 32'(rval[1][0]), 32'h1);
    check("lit t1 data L2", rdat[1][0], 32'hDEAD_BEEF);
    step();

    // Partial byte-lane write.
    op(0, 1, 0, 7, 4'hF, 32'h1122_3344); step();
    op(0, 1, 0, 7, 4'b0101, 32'hAABB_CCDD); step();
    op(0, 0, 1, 7, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t2 lanes", rdat[0][0], 32'h11BB_33DD);
    step(); #2;
    check("lit t2 lanes L2", rdat[1][0], 32'h11BB_33DD);
    step();

    // Write/write collision, then read-during-write across ports.
    op(0, 1, 0, 9, 4'h3, 32'h0000_FFFF);
    op(1, 1, 0, 9, 4'hF, 32'h1234_5678); step();
    idle();
    op(0, 0, 1, 9, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t3 ww", rdat[0][0], 32'h1234_FFFF);
    op(0, 1, 0, 9, 4'hF, 32'hCAFE_F00D);
    op(1, 0, 1, 9, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t3 old data", rdat[0][1], 32'h1234_FFFF);
    op(0, 0, 1, 9, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t3 new word", rdat[0][0], 32'hCAFE_F00D);
    step();

    // Read and write together is a write only.
    op(0, 1, 1, 6, 4'hF, 32'h6666_6666); step();
    idle(); #2;
    check("lit write wins", 32'(rval[0][0]), 32'h0);
    op(0, 0, 1, 6, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit write wins data", rdat[0][0], 32'h6666_6666);
    step(); step();

    // Back-to-back reads with a two-cycle clken stall mid-stream.
    vcount = 0;
    op(0, 0, 1, 0, 4'h0, 32'h0); step();
    op(0, 0, 1, 1, 4'h0, 32'h0); step();
    clken = 1'b0;
    op(0, 0, 1, 2, 4'h0, 32'h0); step(); step();
    clken = 1'b1; step();
    op(0, 0, 1, 3, 4'h0, 32'h0); step();
    idle(); step(); step(); step();
    check("lit stall beat count", 32'(vcount), 32'd4);

    // Write blocked by reset_req.
    reset_req = 1'b1;
    op(0, 1, 0, 5, 4'hF, 32'h0); step();
    reset_req = 1'b0;
    idle(); step();

    // Reset one cycle after a read is accepted; access in the reset cycle is ignored.
    op(0, 0, 1, 5, 4'h0, 32'h0); step();
    reset = 1'b1;
    op(0, 1, 0, 5, 4'hF, 32'h0); #2;
    check("lit t5 valid in reset", 32'(rval[0][0]), 32'h0);
    check("lit t5 data in reset", rdat[0][0], 32'h0);
    step();
    reset = 1'b0;
    idle(); #2;
    check("lit t5 L2 dropped", 32'(rval[1][0]), 32'h0);
    check("lit t5 L2 data", rdat[1][0], 32'h0);
    step();
    op(0, 0, 1, 5, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t5 retained", rdat[0][0], 32'hDEAD_BEEF);
    step();

    // Out-of-range access on the 1000-word instance.
    op(0, 1, 0, 1020, 4'hF, 32'h55AA_55AA); step();
    op(0, 0, 1, 1020, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t6 oor valid", 32'(rval[2][0]), 32'h1);
    check("lit t6 oor data", rdat[2][0], 32'h0);
    check("lit t6 inrange data", rdat[0][0], 32'h55AA_55AA);
    op(0, 0, 1, 4, 4'h0, 32'h0); step();
    idle(); #2;
    check("lit t6 no alias", rdat[2][0], 32'h0404_0404);

    repeat (4) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
